// File: rtl/umstr_udp_len_buffer.sv
// umstr_udp_len_buffer
//   Store-and-forward buffer that sits after the UDP packer. It stores the
//   payload words of a packet and counts its bytes. When the packet's last
//   beat arrives, it queues one descriptor holding the header and the byte
//   count. The output side then replays the packet with the header, the UDP
//   length and the IP length, and these values stay stable for the whole
//   packet.
//
//   Handshake (both stream ports): a beat moves only on a posedge where tvld
//   and trdy are both high. A source holds tvld and all t* fields stable
//   until that edge. in_trdy_o is decoded from registers only.
//
// Ports
//   clk, reset                  clock and asynchronous active-high reset
//   in_hdr_*_i                  packet header, sampled on the first beat
//   in_tdata_i/tvld/tlast/tkeep payload stream in; byte0 = tdata[31:24]
//   in_trdy_o                   input ready
//   out_hdr_*_o                 header of the packet at the head of the queue
//   out_udp_len_o/out_ip_len_o  payload bytes + 8 / payload bytes + 28
//   out_tdata_o/tvld/tlast/tkeep payload stream out; out_trdy_i is ready
//   err_oversize_o              one-cycle pulse after a truncated packet ends
//   dbg_in_state_o              input FSM state (0 = IDLE, 1 = BODY)
module umstr_udp_len_buffer #(
  parameter int DATA_AW   = 10,
  parameter int DESC_AW   = 4,
  parameter int MAX_BYTES = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] in_hdr_mac_dest_i,
  input  logic [47:0] in_hdr_mac_src_i,
  input  logic [31:0] in_hdr_ip_dest_i,
  input  logic [31:0] in_hdr_ip_src_i,
  input  logic [15:0] in_hdr_port_dest_i,
  input  logic [15:0] in_hdr_port_src_i,
  input  logic [31:0] in_tdata_i,
  input  logic        in_tvld_i,
  input  logic        in_tlast_i,
  input  logic [3:0]  in_tkeep_i,
  output logic        in_trdy_o,
  output logic [47:0] out_hdr_mac_dest_o,
  output logic [47:0] out_hdr_mac_src_o,
  output logic [31:0] out_hdr_ip_dest_o,
  output logic [31:0] out_hdr_ip_src_o,
  output logic [15:0] out_hdr_port_dest_o,
  output logic [15:0] out_hdr_port_src_o,
  output logic [15:0] out_udp_len_o,
  output logic [15:0] out_ip_len_o,
  output logic [31:0] out_tdata_o,
  output logic        out_tvld_o,
  output logic        out_tlast_o,
  output logic [3:0]  out_tkeep_o,
  input  logic        out_trdy_i,
  output logic        err_oversize_o,
  output logic        dbg_in_state_o
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);
  localparam int HDR_W  = 192;
  localparam int DESC_W = HDR_W + 16;

  typedef enum logic {IN_IDLE = 1'b0, IN_BODY = 1'b1} in_state_e;

  in_state_e         in_state_q, in_state_d;
  logic              rst_done_q;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [HDR_W-1:0]  hdr_q, hdr_in, hdr_sel;
  logic              err_q;

  // The payload FIFO stores {tkeep, tdata} only. tlast on the output is
  // rebuilt from the descriptor length. This lets a truncated packet end on
  // a word that was already written.
  logic [35:0]       data_mem [1 << DATA_AW];
  logic [DATA_AW:0]  data_wr_ptr_q, data_rd_ptr_q;
  logic [DESC_W-1:0] desc_mem [1 << DESC_AW];
  // desc_vis_ptr_q trails desc_wr_ptr_q by one cycle. The output side sees a
  // new descriptor one edge after it is pushed, which gives tlast-to-first-beat
  // a latency of two edges.
  logic [DESC_AW:0]  desc_wr_ptr_q, desc_vis_ptr_q, desc_rd_ptr_q;

  logic              data_full, desc_full;
  logic              in_fire, out_fire, out_last;
  logic              data_wr_en, desc_wr_en, hdr_capture, trunc_end, cnt_full;
  logic [35:0]       wr_word;
  logic [15:0]       desc_len, last_bytes;
  logic [3:0]        last_keep;
  logic [DESC_W-1:0] head_desc;
  logic [35:0]       head_word;
  logic [15:0]       out_len, out_bytes_q;

  assign data_full = (data_wr_ptr_q[DATA_AW] != data_rd_ptr_q[DATA_AW]) &&
                     (data_wr_ptr_q[DATA_AW-1:0] == data_rd_ptr_q[DATA_AW-1:0]);
  assign desc_full = (desc_wr_ptr_q[DESC_AW] != desc_rd_ptr_q[DESC_AW]) &&
                     (desc_wr_ptr_q[DESC_AW-1:0] == desc_rd_ptr_q[DESC_AW-1:0]);

  // rst_done_q holds ready low during reset and for the edge that releases it.
  assign in_trdy_o = rst_done_q && !data_full && !desc_full;
  assign in_fire   = in_tvld_i && in_trdy_o;

  assign hdr_in  = {in_hdr_mac_dest_i, in_hdr_mac_src_i, in_hdr_ip_dest_i,
                    in_hdr_ip_src_i, in_hdr_port_dest_i, in_hdr_port_src_i};
  // A one-beat packet pushes its descriptor before hdr_q can be loaded, so
  // the beat accepted in IDLE uses the live header inputs.
  assign hdr_sel = (in_state_q == IN_IDLE) ? hdr_in : hdr_q;
  assign cnt_full = (byte_cnt_q >= MAX_LEN);

  // Last-beat keep: only prefix patterns are legal; anything else is a full word.
  always_comb begin
    last_bytes = 16'd4;
    last_keep  = 4'b1111;
    case (in_tkeep_i)
      4'b1110: begin last_bytes = 16'd3; last_keep = 4'b1110; end
      4'b1100: begin last_bytes = 16'd2; last_keep = 4'b1100; end
      4'b1000: begin last_bytes = 16'd1; last_keep = 4'b1000; end
      default: begin last_bytes = 16'd4; last_keep = 4'b1111; end
    endcase
  end

  // Input FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_state_q <= IN_IDLE;
    else       in_state_q <= in_state_d;
  end

  // Input FSM: next state
  always_comb begin
    in_state_d = in_state_q;
    if (in_fire) begin
      if (in_state_q == IN_IDLE && !in_tlast_i)     in_state_d = IN_BODY;
      else if (in_state_q == IN_BODY && in_tlast_i) in_state_d = IN_IDLE;
    end
  end

  // Input FSM: datapath controls
  always_comb begin
    hdr_capture = 1'b0;
    data_wr_en  = 1'b0;
    desc_wr_en  = 1'b0;
    trunc_end   = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    wr_word     = {in_tkeep_i, in_tdata_i};
    desc_len    = 16'd0;
    if (in_fire) begin
      hdr_capture = (in_state_q == IN_IDLE);
      if (!in_tlast_i) begin
        // Once the count reaches MAX_LEN, later body beats are accepted and dropped.
        if (!cnt_full) begin
          data_wr_en = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd4;
        end
      end else begin
        desc_wr_en = 1'b1;
        byte_cnt_d = 16'd0;
        if (cnt_full) begin
          trunc_end = 1'b1;
          desc_len  = MAX_LEN;
        end else begin
          data_wr_en = 1'b1;
          wr_word    = {last_keep, in_tdata_i};
          desc_len   = byte_cnt_q + last_bytes;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_done_q     <= 1'b0;
      byte_cnt_q     <= 16'd0;
      hdr_q          <= '0;
      err_q          <= 1'b0;
      data_wr_ptr_q  <= '0;
      data_rd_ptr_q  <= '0;
      desc_wr_ptr_q  <= '0;
      desc_vis_ptr_q <= '0;
      desc_rd_ptr_q  <= '0;
      out_bytes_q    <= 16'd0;
    end else begin
      rst_done_q     <= 1'b1;
      byte_cnt_q     <= byte_cnt_d;
      err_q          <= trunc_end;
      desc_vis_ptr_q <= desc_wr_ptr_q;
      if (hdr_capture) hdr_q <= hdr_in;
      if (data_wr_en)  data_wr_ptr_q <= data_wr_ptr_q + (DATA_AW+1)'(1);
      if (desc_wr_en)  desc_wr_ptr_q <= desc_wr_ptr_q + (DESC_AW+1)'(1);
      if (out_fire) begin
        data_rd_ptr_q <= data_rd_ptr_q + (DATA_AW+1)'(1);
        if (out_last) begin
          desc_rd_ptr_q <= desc_rd_ptr_q + (DESC_AW+1)'(1);
          out_bytes_q   <= 16'd0;
        end else begin
          out_bytes_q   <= out_bytes_q + 16'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr_en) data_mem[data_wr_ptr_q[DATA_AW-1:0]] <= wr_word;
    if (desc_wr_en) desc_mem[desc_wr_ptr_q[DESC_AW-1:0]] <= {hdr_sel, desc_len};
  end

  // Output side: a packet is valid while its descriptor is visible. The last
  // beat is the one that covers the final byte of the recorded length.
  assign out_tvld_o = (desc_rd_ptr_q != desc_vis_ptr_q);
  assign head_desc  = desc_mem[desc_rd_ptr_q[DESC_AW-1:0]];
  assign head_word  = data_mem[data_rd_ptr_q[DATA_AW-1:0]];
  assign out_len    = head_desc[15:0];
  assign out_last   = ({1'b0, out_bytes_q} + 17'd4) >= {1'b0, out_len};
  assign out_fire   = out_tvld_o && out_trdy_i;

  always_comb begin
    {out_hdr_mac_dest_o, out_hdr_mac_src_o, out_hdr_ip_dest_o,
     out_hdr_ip_src_o, out_hdr_port_dest_o, out_hdr_port_src_o} = '0;
    out_udp_len_o = 16'd0;
    out_ip_len_o  = 16'd0;
    out_tdata_o   = 32'd0;
    out_tkeep_o   = 4'd0;
    out_tlast_o   = 1'b0;
    if (out_tvld_o) begin
      {out_hdr_mac_dest_o, out_hdr_mac_src_o, out_hdr_ip_dest_o,
       out_hdr_ip_src_o, out_hdr_port_dest_o, out_hdr_port_src_o} = head_desc[DESC_W-1:16];
      out_udp_len_o = out_len + 16'd8;
      out_ip_len_o  = out_len + 16'd28;
      out_tdata_o   = head_word[31:0];
      out_tkeep_o   = head_word[35:32];
      out_tlast_o   = out_last;
    end
  end

  assign err_oversize_o = err_q;
  assign dbg_in_state_o = in_state_q;

endmodule

// File: tb/tb_umstr_udp_len_buffer.sv
// Bench for umstr_udp_len_buffer: clock/reset, input driver tasks, an output
// scoreboard fed by a byte-count/truncation model, and a summary report.
module tb_umstr_udp_len_buffer;

  localparam int MAXB  = 1472;
  localparam int EXP_W = 261;  // {hdr 192, udp 16, ip 16, last 1, keep 4, data 32}

  logic        clk;
  logic        reset;
  logic [47:0] in_hdr_mac_dest_i, in_hdr_mac_src_i;
  logic [31:0] in_hdr_ip_dest_i, in_hdr_ip_src_i;
  logic [15:0] in_hdr_port_dest_i, in_hdr_port_src_i;
  logic [31:0] in_tdata_i;
  logic        in_tvld_i, in_tlast_i;
  logic [3:0]  in_tkeep_i;
  logic        in_trdy_o;
  logic [47:0] out_hdr_mac_dest_o, out_hdr_mac_src_o;
  logic [31:0] out_hdr_ip_dest_o, out_hdr_ip_src_o;
  logic [15:0] out_hdr_port_dest_o, out_hdr_port_src_o;
  logic [15:0] out_udp_len_o, out_ip_len_o;
  logic [31:0] out_tdata_o;
  logic        out_tvld_o, out_tlast_o;
  logic [3:0]  out_tkeep_o;
  logic        out_trdy_i;
  logic        err_oversize_o;
  logic        dbg_in_state_o;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_beat;
  int n_checks   = 0;
  int n_errors   = 0;
  int exp_err    = 0;
  int err_cycles = 0;
  int trdy_mode  = 1;    // 0 = stalled, 1 = always ready, 2 = random
  logic rand_bit = 1'b1;
  logic [3:0] keep_tab [7] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h5, 4'h0, 4'h3};

  assign out_trdy_i = (trdy_mode == 2) ? rand_bit : (trdy_mode == 1);

  umstr_udp_len_buffer dut (
    .clk(clk), .reset(reset),
    .in_hdr_mac_dest_i(in_hdr_mac_dest_i), .in_hdr_mac_src_i(in_hdr_mac_src_i),
    .in_hdr_ip_dest_i(in_hdr_ip_dest_i), .in_hdr_ip_src_i(in_hdr_ip_src_i),
    .in_hdr_port_dest_i(in_hdr_port_dest_i), .in_hdr_port_src_i(in_hdr_port_src_i),
    .in_tdata_i(in_tdata_i), .in_tvld_i(in_tvld_i), .in_tlast_i(in_tlast_i),
    .in_tkeep_i(in_tkeep_i), .in_trdy_o(in_trdy_o),
    .out_hdr_mac_dest_o(out_hdr_mac_dest_o), .out_hdr_mac_src_o(out_hdr_mac_src_o),
    .out_hdr_ip_dest_o(out_hdr_ip_dest_o), .out_hdr_ip_src_o(out_hdr_ip_src_o),
    .out_hdr_port_dest_o(out_hdr_port_dest_o), .out_hdr_port_src_o(out_hdr_port_src_o),
    .out_udp_len_o(out_udp_len_o), .out_ip_len_o(out_ip_len_o),
    .out_tdata_o(out_tdata_o), .out_tvld_o(out_tvld_o), .out_tlast_o(out_tlast_o),
    .out_tkeep_o(out_tkeep_o), .out_trdy_i(out_trdy_i),
    .err_oversize_o(err_oversize_o), .dbg_in_state_o(dbg_in_state_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) rand_bit <= ($urandom_range(0, 3) != 0);

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [191:0] rand_hdr();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int keep_bytes(input logic [3:0] k);
    case (k)
      4'b1110: return 3;
      4'b1100: return 2;
      4'b1000: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] norm_keep(input logic [3:0] k);
    if (k == 4'b1110 || k == 4'b1100 || k == 4'b1000) return k;
    return 4'b1111;
  endfunction

  // Scoreboard monitor: every valid cycle (stalled or not) must match the
  // head of the expected queue; the entry is retired on an accepted beat.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (err_oversize_o) err_cycles++;
      if (out_tvld_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_tvld_o, 1'b0);
        end else begin
          exp_beat = exp_q[0];
          check("out_hdr", {out_hdr_mac_dest_o, out_hdr_mac_src_o, out_hdr_ip_dest_o,
                            out_hdr_ip_src_o, out_hdr_port_dest_o, out_hdr_port_src_o},
                exp_beat[260:69]);
          check("out_udp_len", out_udp_len_o, exp_beat[68:53]);
          check("out_ip_len", out_ip_len_o, exp_beat[52:37]);
          check("out_tlast", out_tlast_o, exp_beat[36]);
          check("out_tkeep", out_tkeep_o, exp_beat[35:32]);
          check("out_tdata", out_tdata_o, exp_beat[31:0]);
          if (out_trdy_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drive one beat from a negedge; returns at the negedge after acceptance.
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input bit l,
                            input logic [191:0] h);
    int g;
    g = 0;
    in_tdata_i = d;
    in_tkeep_i = k;
    in_tlast_i = l;
    in_tvld_i  = 1'b1;
    {in_hdr_mac_dest_i, in_hdr_mac_src_i, in_hdr_ip_dest_i,
     in_hdr_ip_src_i, in_hdr_port_dest_i, in_hdr_port_src_i} = h;
    while (!in_trdy_o && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check("in_trdy_timeout", in_trdy_o, 1'b1);
    @(negedge clk);
    in_tvld_i = 1'b0;
  endtask

  // Build the expected output for one packet, then drive it. Body beats
  // after the first carry random headers, which must be ignored.
  task automatic send_pkt(input int nbeats, input logic [3:0] last_keep,
                          input logic [191:0] hdr, input bit use_first,
                          input logic [31:0] first_word);
    logic [31:0] words[$];
    logic [31:0] sd[$];
    logic [3:0]  sk[$];
    int cnt;
    int len;
    bit trunc;
    cnt   = 0;
    len   = 0;
    trunc = 1'b0;
    for (int i = 0; i < nbeats; i++)
      words.push_back((i == 0 && use_first) ? first_word : $urandom);
    for (int i = 0; i < nbeats - 1; i++) begin
      if (cnt < MAXB) begin
        sd.push_back(words[i]);
        sk.push_back(4'hF);
        cnt += 4;
      end
    end
    if (cnt >= MAXB) begin
      trunc = 1'b1;
      len   = MAXB;
    end else begin
      sd.push_back(words[nbeats-1]);
      sk.push_back(norm_keep(last_keep));
      len = cnt + keep_bytes(last_keep);
    end
    for (int i = 0; i < sd.size(); i++)
      exp_q.push_back({hdr, 16'(len + 8), 16'(len + 28), (i == sd.size() - 1), sk[i], sd[i]});
    for (int i = 0; i < nbeats; i++)
      drive_beat(words[i], (i == nbeats - 1) ? last_keep : 4'hF, (i == nbeats - 1),
                 (i == 0) ? hdr : rand_hdr());
    check("err_pulse", err_oversize_o, trunc);
    if (trunc) exp_err++;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int run;
    int g;
    reset     = 1'b1;
    in_tvld_i = 1'b0;
    in_tlast_i = 1'b0;
    in_tkeep_i = 4'h0;
    in_tdata_i = 32'h0;
    {in_hdr_mac_dest_i, in_hdr_mac_src_i, in_hdr_ip_dest_i,
     in_hdr_ip_src_i, in_hdr_port_dest_i, in_hdr_port_src_i} = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_trdy", in_trdy_o, 1'b0);
    check("rst_out_tvld", out_tvld_o, 1'b0);
    check("rst_err", err_oversize_o, 1'b0);
    check("rst_out_tdata", out_tdata_o, 32'h0);
    check("rst_udp_len", out_udp_len_o, 16'h0);
    check("rst_state", dbg_in_state_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("trdy_after_rst", in_trdy_o, 1'b1);

    // One-beat packet, keep 1100
    trdy_mode = 1;
    send_pkt(1, 4'b1100, rand_hdr(), 1'b1, 32'hAABB0000);
    wait_drain();

    // Latency: tlast at edge N gives valid at edge N+2
    send_pkt(1, 4'b1111, rand_hdr(), 1'b0, 32'h0);
    check("lat_n1_vld", out_tvld_o, 1'b0);
    @(negedge clk);
    check("lat_n2_vld", out_tvld_o, 1'b1);
    wait_drain();

    // Back-to-back A (3 beats) and B (2 beats): five contiguous valid cycles
    fork
      begin
        send_pkt(3, 4'b1111, rand_hdr(), 1'b0, 32'h0);
        send_pkt(2, 4'b1000, rand_hdr(), 1'b0, 32'h0);
      end
      begin
        g = 0;
        run = 0;
        while (!out_tvld_o && g < 100) begin
          @(negedge clk);
          #2;
          g++;
        end
        while (out_tvld_o && run < 20) begin
          run++;
          @(negedge clk);
          #2;
        end
        check("b2b_run", 32'(run), 32'd5);
      end
    join
    wait_drain();

    // 100-beat packet with output stalled, then released
    trdy_mode = 0;
    send_pkt(100, 4'b1110, rand_hdr(), 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    check("stall_vld", out_tvld_o, 1'b1);
    trdy_mode = 2;
    wait_drain();

    // Oversize: 400 full beats truncate to MAXB
    send_pkt(400, 4'b1111, rand_hdr(), 1'b0, 32'h0);
    wait_drain();

    // Descriptor FIFO full after 16 packets; one pop frees a slot
    trdy_mode = 0;
    for (int i = 0; i < 16; i++) send_pkt(1, 4'b1111, rand_hdr(), 1'b0, 32'h0);
    check("desc_full_trdy", in_trdy_o, 1'b0);
    trdy_mode = 1;
    @(negedge clk);
    trdy_mode = 0;
    check("desc_pop_trdy", in_trdy_o, 1'b1);
    trdy_mode = 2;
    wait_drain();

    // Random packets, random downstream ready
    for (int i = 0; i < 25; i++)
      send_pkt($urandom_range(1, 20), keep_tab[$urandom_range(0, 6)], rand_hdr(), 1'b0, 32'h0);
    wait_drain();

    // Reset during beat 5 of a packet: that packet vanishes, next one is intact
    trdy_mode = 1;
    drive_beat($urandom, 4'hF, 1'b0, rand_hdr());
    for (int i = 0; i < 3; i++) drive_beat($urandom, 4'hF, 1'b0, rand_hdr());
    in_tdata_i = $urandom;
    in_tvld_i  = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    check("midrst_in_trdy", in_trdy_o, 1'b0);
    check("midrst_out_tvld", out_tvld_o, 1'b0);
    check("midrst_state", dbg_in_state_o, 1'b0);
    @(negedge clk);
    in_tvld_i = 1'b0;
    reset     = 1'b0;
    check("rel_in_trdy_low", in_trdy_o, 1'b0);
    @(negedge clk);
    check("rel_in_trdy_high", in_trdy_o, 1'b1);
    send_pkt(6, 4'b1100, rand_hdr(), 1'b0, 32'h0);
    wait_drain();

    check("err_cycles", 32'(err_cycles), 32'(exp_err));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/umstr_udp_len_buffer.md
UMSTR_UDP_LEN_BUFFER -- requirements
Module: umstr_udp_len_buffer

Interface
REQ-001 SHALL have parameter DATA_AW, default 10, meaning log2 of payload FIFO depth in 32-bit words; legal values are 9 or greater.
REQ-002 SHALL have parameter DESC_AW, default 4, meaning log2 of descriptor FIFO depth in packets.
REQ-003 SHALL have parameter MAX_BYTES, default 1472, meaning maximum UDP payload bytes per packet.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_hdr_mac_dest_i/in_hdr_mac_src_i  in  48 each  header from the packer; sampled on the first beat.
REQ-007 in_hdr_ip_dest_i/in_hdr_ip_src_i  in  32 each  header; sampled on the first beat.
REQ-008 in_hdr_port_dest_i/in_hdr_port_src_i  in  16 each  header; sampled on the first beat.
REQ-009 in_tdata_i 32, in_tvld_i 1, in_tlast_i 1, in_tkeep_i 4  in  payload stream; byte0 = tdata[31:24] = tkeep[3].
REQ-010 in_trdy_o  out  1  input ready.
REQ-011 out_hdr_* (same six fields and widths as REQ-006 to REQ-008)  out  header of the current output packet.
REQ-012 out_udp_len_o  out  16  payload bytes + 8.
REQ-013 out_ip_len_o  out  16  payload bytes + 28.
REQ-014 out_tdata_o 32, out_tvld_o 1, out_tlast_o 1, out_tkeep_o 4  out  payload stream.
REQ-015 out_trdy_i  in  1  downstream ready.
REQ-016 err_oversize_o  out  1  one-cycle pulse when a packet was truncated.

Function
REQ-017 SHALL transfer a beat on either side only when tvld and trdy are both high on the same clk edge.
REQ-018 in_trdy_o SHALL equal (payload FIFO not full) AND (descriptor FIFO not full), decoded from registered state only.
REQ-019 Input-side FSM SHALL have states IDLE and BODY: IDLE goes to BODY on an accepted non-last beat; BODY goes to IDLE on an accepted last beat; an accepted beat with tlast in IDLE is a one-beat packet and stays in IDLE.
REQ-020 SHALL capture all six header fields on the beat accepted in IDLE; header inputs SHALL be ignored in BODY.
REQ-021 Byte count SHALL add 4 per non-last beat and, on the last beat, add popcount-by-prefix: 1111=4, 1110=3, 1100=2, 1000=1; any other tkeep pattern counts 4 and is forwarded as 1111.
REQ-022 Byte-count arithmetic SHALL be 16-bit unsigned; once the count reaches MAX_BYTES, further non-last beats SHALL be accepted and discarded, not written to the payload FIFO.
REQ-023 On the tlast of a truncated packet: write no data word, mark the last stored word tlast with its tkeep unchanged, report length MAX_BYTES, and pulse err_oversize_o for 1 cycle on the cycle after the tlast acceptance.
REQ-024 On tlast acceptance SHALL push descriptor {header, byte count} into the descriptor FIFO in the same cycle as the final data write.
REQ-025 Output side SHALL assert out_tvld_o only while a descriptor is present; the output header and lengths SHALL come from the head descriptor and stay stable from first to last beat.
REQ-026 SHALL pop the descriptor on the accepted out_tlast_o beat; the next packet SHALL begin in the following cycle, with no idle gap when it is already available.
REQ-027 Latency: with both FIFOs empty and out_trdy_i high, tlast accepted at edge N SHALL give the first output beat valid at edge N+2.
REQ-028 out_t* SHALL hold while out_tvld_o=1 and out_trdy_i=0; stalls SHALL never drop or duplicate beats.
REQ-029 Simultaneous push and pop on the payload FIFO or the descriptor FIFO SHALL be legal at any occupancy, including full and empty.
REQ-030 FIFO pointers SHALL wrap modulo depth, using an extra MSB for full/empty discrimination.

Reset
REQ-031 While reset=1: both FIFOs flushed, FSM set to IDLE, byte count set to 0, in_trdy_o=0, out_tvld_o=0, err_oversize_o=0, and all other outputs set to 0.
REQ-032 A reset asserted mid-packet on either side SHALL discard the partial packet; in_trdy_o SHALL rise on the first edge after reset deasserts.

Verification
REQ-033 One-beat packet, tkeep=1100, data 0xAABB0000 -> one output beat with tlast=1, tkeep=1100, out_udp_len_o=10, out_ip_len_o=30.
REQ-034 100-beat packet, last tkeep=1110, out_trdy_i held low throughout -> out_tvld_o=1 with headers stable; after release, 100 beats in order, udp_len=407.
REQ-035 400 full beats with MAX_BYTES=1472 -> 368 beats output, last beat tlast=1, udp_len=1480, err_oversize_o single pulse.
REQ-036 Back-to-back packets A (3 beats) and B (2 beats) with differing headers, out_trdy_i=1 -> 5 consecutive valid beats; header switches exactly at B's first beat.
REQ-037 Fill descriptor FIFO with 16 one-beat packets, output stalled -> in_trdy_o=0 after the 16th; one pop restores in_trdy_o=1 the next cycle.
REQ-038 Reset pulsed during the beat 5 input of a packet -> no output for that packet; the next packet is output intact with the correct length.
